vga_fb_reader: RTL

VGA_FB_READER -- requirements
Module: vga_fb_reader

---
 rtl/vga_fb_reader_if.sv | 31 +++
 rtl/vga_fb_reader.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/vga_fb_reader_if.sv
// Framebuffer-read and VGA output bundle for vga_fb_reader.
// The reader drives the address and video outputs; memory returns fb_rdata one clock after fb_raddr.
interface vga_fb_reader_if;
  logic [18:0] fb_raddr;
  logic [7:0]  fb_rdata;
  logic [7:0]  vga_pixel;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_blank_n;
  logic        frame_start;

  modport master (
    output fb_raddr,
    input  fb_rdata,
    output vga_pixel,
    output vga_hsync,
    output vga_vsync,
    output vga_blank_n,
    output frame_start
  );

  modport slave (
    input  fb_raddr,
    output fb_rdata,
    input  vga_pixel,
    input  vga_hsync,
    input  vga_vsync,
    input  vga_blank_n,
    input  frame_start
  );
endinterface

// File: rtl/vga_fb_reader.sv
// VGA scan-out from an 8-bit framebuffer with a 1-clock read latency; outputs lag the counters by 3 clocks.
// Optional feature: define VGA_BORDER_EN to paint the outermost visible ring with BORDER_COLOR.
module vga_fb_reader #(
  parameter int         H_ACTIVE     = 640,
  parameter int         V_ACTIVE     = 480,
  parameter logic [7:0] BORDER_COLOR = 8'hFF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  vga_fb_reader_if.master  bus
);

  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_MAX   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_MAX   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [18:0]   A_LAST  = 19'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t          state;
  logic [HW-1:0]   h;
  logic [VW-1:0]   v;
  logic [18:0]     addr_cnt;

  // Stage 1 lines up with fb_raddr, stage 2 with fb_rdata.
  logic            vis1, hs1, vs1, fs1;
  logic            vis2, hs2, vs2, fs2;

  logic            active;
  logic            at_end;
  logic            visible;
  logic            hs_on;
  logic            vs_on;

  assign active  = (state != IDLE);
  assign at_end  = (h == H_MAX) && (v == V_MAX);
  assign visible = active && (h < H_VIS) && (v < V_VIS);
  assign hs_on   = active && (h >= HS_BEG) && (h < HS_END);
  assign vs_on   = active && (v >= VS_BEG) && (v < VS_END);

`ifdef VGA_BORDER_EN
  logic            edge1, edge2;
`else
  // Border colour has no consumer in this build.
  logic            unused_border;
  assign unused_border = ^BORDER_COLOR;
`endif

  // NOTE: every register here, FSM included, lives in this one clocked block and uses
  // non-blocking assignments, so each right-hand side reads the pre-edge value of the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      h               <= '0;
      v               <= '0;
      addr_cnt        <= '0;
      bus.fb_raddr    <= '0;
      vis1            <= 1'b0;
      hs1             <= 1'b1;
      vs1             <= 1'b1;
      fs1             <= 1'b0;
      vis2            <= 1'b0;
      hs2             <= 1'b1;
      vs2             <= 1'b1;
      fs2             <= 1'b0;
`ifdef VGA_BORDER_EN
      edge1           <= 1'b0;
      edge2           <= 1'b0;
`endif
      bus.vga_pixel   <= '0;
      bus.vga_hsync   <= 1'b1;
      bus.vga_vsync   <= 1'b1;
      bus.vga_blank_n <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      // A frame, once started, always runs to its last count; enable only matters at frame boundaries.
      unique case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (at_end) state <= enable ? RUN : IDLE;
                 else if (!enable) state <= DRAIN;
        DRAIN:   if (at_end) state <= enable ? RUN : IDLE;
        default: state <= IDLE;
      endcase

      if (!active || at_end) begin
        h <= '0;
        v <= '0;
      end else if (h == H_MAX) begin
        h <= '0;
        v <= v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end

      // Linear address tracks the raster; it wraps on the last visible pixel so it never overshoots.
      if (!active) begin
        addr_cnt     <= '0;
        bus.fb_raddr <= '0;
      end else if (visible) begin
        bus.fb_raddr <= addr_cnt;
        addr_cnt     <= (addr_cnt == A_LAST) ? '0 : addr_cnt + 19'd1;
      end else if (at_end) begin
        addr_cnt     <= '0;
        bus.fb_raddr <= '0;
      end

      vis1 <= visible;
      hs1  <= !hs_on;
      vs1  <= !vs_on;
      fs1  <= active && (h == '0) && (v == '0);
      vis2 <= vis1;
      hs2  <= hs1;
      vs2  <= vs1;
      fs2  <= fs1;

      bus.vga_hsync   <= hs2;
      bus.vga_vsync   <= vs2;
      bus.vga_blank_n <= vis2;
      bus.frame_start <= fs2;
`ifdef VGA_BORDER_EN
      edge1 <= (h == '0) || (h == H_VIS - 1'b1) || (v == '0) || (v == V_VIS - 1'b1);
      edge2 <= edge1;
      if (!vis2)      bus.vga_pixel <= '0;
      else if (edge2) bus.vga_pixel <= BORDER_COLOR;
      else            bus.vga_pixel <= bus.fb_rdata;
`else
      bus.vga_pixel <= vis2 ? bus.fb_rdata : '0;
`endif
    end
  end

endmodule
